icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the pipelined CPU's fetch port (`inst_read`/`inst_addr` in, `inst_rdata`/`inst_resp` out). It fills 256-bit lines from physical memory as four 64-bit burst beats. It sits between the CPU top's IF stage and the memory arbiter/cacheline path, and is the responder end of the instruction-fetch interface.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_array.sv | 62 ++++++
 rtl/icache.sv | 158 +++++++++++++++
 tb/tb_icache.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_types;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned BEAT_W   = 64;
  localparam int unsigned BEATS    = 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_A_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } icache_state_t;

  function automatic int unsigned tag_w(input int unsigned s_index);
    return LINE_A_W - s_index;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: beat-wide fill port, combinational lookup.
module icache_array
  import icache_types::*;
#(
  parameter int unsigned S_INDEX = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [S_INDEX-1:0]          wr_index,
  input  logic [BEATS-1:0]            wr_beat,
  input  logic [BEAT_W-1:0]           wr_data,
  input  logic                        wr_validate,
  input  logic [tag_w(S_INDEX)-1:0]   wr_tag,
  input  logic [S_INDEX-1:0]          rd_index,
  input  logic [tag_w(S_INDEX)-1:0]   rd_tag,
  input  logic [2:0]                  rd_word_sel,
  output logic                        hit,
  output logic [WORD_W-1:0]           rd_word
);

  localparam int unsigned LINES = 1 << S_INDEX;
  localparam int unsigned TAG_W = tag_w(S_INDEX);

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [LINE_W-1:0] data_r [LINES];
  logic [LINE_W-1:0] line_s;

  // Valid bits: cleared by reset, set only when the last beat of a fill lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (wr_validate) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag written together with the validating beat.
  always_ff @(posedge clk) begin
    if (wr_validate) begin
      tag_r[wr_index] <= wr_tag;
    end
  end

  // Data: one 64-bit slice per beat, selected by the one-hot beat vector.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BEATS; k++) begin
      if (wr_en && wr_beat[k]) begin
        data_r[wr_index][k*BEAT_W +: BEAT_W] <= wr_data;
      end
    end
  end

  // Lookup of the addressed line and word.
  always_comb begin
    line_s  = data_r[rd_index];
    rd_word = line_s[rd_word_sel*WORD_W +: WORD_W];
    hit     = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 4-beat line fill.
// Optional ICACHE_PERF_EN macro builds the hit/miss counters.
module icache
  import icache_types::*;
#(
  parameter int unsigned S_INDEX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_read,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [WORD_W-1:0]   inst_rdata,
  output logic                inst_resp,
  output logic                pmem_read,
  output logic [ADDR_W-1:0]   pmem_address,
  input  logic [BEAT_W-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int unsigned TAG_W = tag_w(S_INDEX);

  icache_state_t       state_r;
  logic [1:0]          beat_cnt_r;
  logic [LINE_A_W-1:0] fill_line_r;
  logic [2:0]          req_word_r;
  logic                pmem_read_r;
  logic                inst_resp_r;
  logic [WORD_W-1:0]   inst_rdata_r;

  logic [LINE_A_W-1:0] lk_line_s;
  logic [2:0]          lk_word_s;
  logic                fill_wr_s;
  logic                last_beat_s;
  logic [BEATS-1:0]    beat_onehot_s;
  logic                hit_s;
  logic [WORD_W-1:0]   rd_word_s;
  logic [WORD_W-1:0]   fill_word_s;

  // Lookup address: live request in IDLE, latched fill line otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      lk_line_s = inst_addr[ADDR_W-1:OFFSET_W];
      lk_word_s = inst_addr[4:2];
    end else begin
      lk_line_s = fill_line_r;
      lk_word_s = req_word_r;
    end
    fill_wr_s     = (state_r == FILL) && pmem_resp;
    last_beat_s   = fill_wr_s && (beat_cnt_r == 2'd3);
    beat_onehot_s = 4'b0001 << beat_cnt_r;
    // Words 6/7 arrive in beat 3 and are not in the array yet.
    if (req_word_r[2:1] == 2'b11) begin
      fill_word_s = req_word_r[0] ? pmem_rdata[63:32] : pmem_rdata[31:0];
    end else begin
      fill_word_s = rd_word_s;
    end
  end

  icache_array #(.S_INDEX(S_INDEX)) u_array (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (fill_wr_s),
    .wr_index    (lk_line_s[S_INDEX-1:0]),
    .wr_beat     (beat_onehot_s),
    .wr_data     (pmem_rdata),
    .wr_validate (last_beat_s),
    .wr_tag      (lk_line_s[LINE_A_W-1:S_INDEX]),
    .rd_index    (lk_line_s[S_INDEX-1:0]),
    .rd_tag      (lk_line_s[LINE_A_W-1:S_INDEX]),
    .rd_word_sel (lk_word_s),
    .hit         (hit_s),
    .rd_word     (rd_word_s)
  );

  // Controller FSM with registered CPU and memory-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      beat_cnt_r   <= 2'd0;
      fill_line_r  <= '0;
      req_word_r   <= 3'd0;
      pmem_read_r  <= 1'b0;
      inst_resp_r  <= 1'b0;
      inst_rdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (inst_read) begin
            if (hit_s) begin
              inst_rdata_r <= rd_word_s;
              inst_resp_r  <= 1'b1;
              state_r      <= RESP;
            end else begin
              fill_line_r <= inst_addr[ADDR_W-1:OFFSET_W];
              req_word_r  <= inst_addr[4:2];
              beat_cnt_r  <= 2'd0;
              pmem_read_r <= 1'b1;
              state_r     <= FILL;
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            beat_cnt_r <= beat_cnt_r + 2'd1;
            if (beat_cnt_r == 2'd3) begin
              pmem_read_r  <= 1'b0;
              inst_rdata_r <= fill_word_s;
              inst_resp_r  <= 1'b1;
              state_r      <= RESP;
            end
          end
        end
        RESP: begin
          inst_resp_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          inst_resp_r <= 1'b0;
          pmem_read_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign inst_rdata   = inst_rdata_r;
  assign inst_resp    = inst_resp_r;
  assign pmem_read    = pmem_read_r;
  assign pmem_address = {fill_line_r, 5'd0};

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Hit/miss counters, bumped on each accepted IDLE lookup; wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if ((state_r == IDLE) && inst_read) begin
      if (hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end else begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: memory model drives fills, expected words queued per fetch.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  icache #(.S_INDEX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory image: line 0x60 holds words 0..7, other lines are offset from it.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input logic [2:0] w);
    return (line - 32'h60) * 32'h100 + {29'd0, w};
  endfunction

  function automatic logic [63:0] mem_beat(input logic [31:0] line, input logic [1:0] k);
    return {mem_word(line, {k, 1'b1}), mem_word(line, {k, 1'b0})};
  endfunction

  task automatic serve_beat(input logic [31:0] line, input logic [1:0] k, input int gap);
    for (int i = 0; i < gap; i++) begin
      pmem_resp = 1'b0;
      @(negedge clk);
      check_eq("fill_hold", {63'd0, pmem_read}, 64'd1);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = mem_beat(line, k);
    @(negedge clk);
    pmem_resp  = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!inst_resp && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    check_eq("resp_seen", {63'd0, inst_resp}, 64'd1);
    if (inst_resp) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 64'd1, 64'd0);
      end else begin
        check_eq("rdata", {32'd0, inst_rdata}, {32'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input bit miss,
                          input int g0, input int g1, input int g2, input int g3);
    logic [31:0] line;
    int lat;
    int gaps[4];
    gaps = '{g0, g1, g2, g3};
    line = {addr[31:5], 5'd0};
    inst_read = 1'b1;
    inst_addr = addr;
    exp_q.push_back(mem_word(line, addr[4:2]));
    @(negedge clk);
    if (miss) begin
      check_eq("miss_pmem_read", {63'd0, pmem_read}, 64'd1);
      check_eq("miss_pmem_addr", {32'd0, pmem_address}, {32'd0, line});
      check_eq("miss_no_resp", {63'd0, inst_resp}, 64'd0);
      for (int k = 0; k < 4; k++) serve_beat(line, k[1:0], gaps[k]);
      check_eq("fill_pmem_low", {63'd0, pmem_read}, 64'd0);
    end else begin
      check_eq("hit_no_pmem", {63'd0, pmem_read}, 64'd0);
    end
    wait_resp(lat);
    check_eq("resp_latency", lat, 64'd0);
    inst_read = 1'b0;
    @(negedge clk);
    check_eq("resp_single", {63'd0, inst_resp}, 64'd0);
    check_eq("pmem_idle", {63'd0, pmem_read}, 64'd0);
  endtask

  task automatic check_counts(input logic [31:0] hits, input logic [31:0] misses);
`ifdef ICACHE_PERF_EN
    check_eq("hit_count", {32'd0, hit_count}, {32'd0, hits});
    check_eq("miss_count", {32'd0, miss_count}, {32'd0, misses});
`else
    check_eq("hit_count_off", {32'd0, hit_count}, 64'd0);
    check_eq("miss_count_off", {32'd0, miss_count}, 64'd0);
    if (hits > misses + 32'd100) $display("note: unused %0d", hits);
`endif
  endtask

  initial begin
    rst        = 1'b0;
    inst_read  = 1'b0;
    inst_addr  = 32'd0;
    pmem_rdata = 64'd0;
    pmem_resp  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_resp", {63'd0, inst_resp}, 64'd0);
    check_eq("rst_rdata", {32'd0, inst_rdata}, 64'd0);
    check_eq("rst_pmem_read", {63'd0, pmem_read}, 64'd0);
    check_eq("rst_pmem_addr", {32'd0, pmem_address}, 64'd0);
    check_counts(32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_fetch(32'h60, 1'b1, 0, 0, 0, 0);    // cold miss, word 0
    do_fetch(32'h74, 1'b0, 0, 0, 0, 0);    // hit, word 5
    do_fetch(32'h160, 1'b1, 1, 3, 0, 5);   // conflict miss, irregular beats
    do_fetch(32'h17c, 1'b0, 0, 0, 0, 0);   // word 7 of the new line
    do_fetch(32'h60, 1'b1, 0, 2, 0, 0);    // evicted line misses again
    check_counts(32'd2, 32'd3);

    // Reset after beat 1 of a fill for 0x200
    inst_read = 1'b1;
    inst_addr = 32'h200;
    @(negedge clk);
    check_eq("rf_pmem_read", {63'd0, pmem_read}, 64'd1);
    serve_beat(32'h200, 2'd0, 0);
    serve_beat(32'h200, 2'd1, 0);
    rst       = 1'b0;
    inst_read = 1'b0;
    @(negedge clk);
    check_eq("rf_pmem_low", {63'd0, pmem_read}, 64'd0);
    check_eq("rf_resp_low", {63'd0, inst_resp}, 64'd0);
    check_eq("rf_pmem_addr", {32'd0, pmem_address}, 64'd0);
    check_counts(32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 3 misses and 5 hits after reset
    do_fetch(32'h200, 1'b1, 0, 1, 0, 0);
    do_fetch(32'h204, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h21c, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h78, 1'b1, 0, 0, 0, 0);
    do_fetch(32'h7c, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h408, 1'b1, 2, 0, 1, 0);
    do_fetch(32'h404, 1'b0, 0, 0, 0, 0);
    do_fetch(32'h41c, 1'b0, 0, 0, 0, 0);
    check_counts(32'd5, 32'd3);

    // A stray memory beat while idle must not produce a response
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check_eq("idle_beat_ignored", {63'd0, inst_resp}, 64'd0);
    check_eq("sb_drained", exp_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
